// File: rtl/perceptron_trainer_pkg.sv
// Shared fixed-point format, saturation limits and controller state encoding
// for the perceptron training sequencer.
package perceptron_pkg;
   localparam int FP_INTEGER_WIDTH = 4;
   localparam int FP_FRACT_WIDTH   = 12;
   localparam int FP_WIDTH         = FP_INTEGER_WIDTH + FP_FRACT_WIDTH;
   localparam int LR_SHIFT         = 4;
   localparam int DEF_NEUR_LATENCY = 2;
   localparam int DEF_MAX_EPOCHS   = 255;

   typedef logic signed [FP_WIDTH-1:0] fp_t;

   localparam fp_t SAT_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
   localparam fp_t SAT_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_EVAL,
      ST_UPDATE,
      ST_EPOCH_END,
      ST_DONE
   } state_t;

   // Clamp a one-bit-wider sum back into fp_t; overflow shows as differing top bits.
   function automatic fp_t sat_fp(input logic [FP_WIDTH:0] v);
      if (v[FP_WIDTH] != v[FP_WIDTH-1])
         return v[FP_WIDTH] ? SAT_MIN : SAT_MAX;
      return v[FP_WIDTH-1:0];
   endfunction
endpackage

// File: rtl/perceptron_trainer_if.sv
// Bundle of control, status, sample-RAM and perceptron signals around the trainer.
interface perceptron_trainer_if;
   import perceptron_pkg::*;

   logic       start;
   logic       abort;
   logic [7:0] n_samples;
   logic       busy;
   logic       done;
   logic       converged;
   logic [7:0] epochs;
   logic [7:0] errors_last;
   logic [7:0] sample_addr;
   logic       sample_rd;
   fp_t        sample_x1;
   fp_t        sample_x2;
   logic       sample_target;
   fp_t        neur_IN1;
   fp_t        neur_IN2;
   logic       neur_IN_ld;
   fp_t        neur_result;
   fp_t        neur_weight1;
   fp_t        neur_weight2;
   fp_t        neur_weight1_new;
   fp_t        neur_weight2_new;
   logic       neur_weight_ld;

   // slave: the trainer itself; master: controller, sample RAM and perceptron side.
   modport slave (
      input  start, abort, n_samples, sample_x1, sample_x2, sample_target,
             neur_result, neur_weight1, neur_weight2,
      output busy, done, converged, epochs, errors_last, sample_addr, sample_rd,
             neur_IN1, neur_IN2, neur_IN_ld, neur_weight1_new, neur_weight2_new,
             neur_weight_ld
   );

   modport master (
      output start, abort, n_samples, sample_x1, sample_x2, sample_target,
             neur_result, neur_weight1, neur_weight2,
      input  busy, done, converged, epochs, errors_last, sample_addr, sample_rd,
             neur_IN1, neur_IN2, neur_IN_ld, neur_weight1_new, neur_weight2_new,
             neur_weight_ld
   );
endinterface

// File: rtl/perceptron_trainer_weight_update.sv
// One weight of the perceptron rule: w +/- (x >>> LR_SHIFT), saturated to fp_t.
module perceptron_weight_update
   import perceptron_pkg::*;
(
   input  fp_t  w_i,
   input  fp_t  x_i,
   input  logic sub_i,
   output fp_t  w_new_o
);
   logic [FP_WIDTH:0] w_ext;
   logic [FP_WIDTH:0] step_ext;
   logic [FP_WIDTH:0] sum;
   fp_t               step;

   always_comb begin
      step     = x_i >>> LR_SHIFT;
      w_ext    = {w_i[FP_WIDTH-1], w_i};
      step_ext = {step[FP_WIDTH-1], step};
      sum      = sub_i ? (w_ext - step_ext) : (w_ext + step_ext);
      w_new_o  = sat_fp(sum);
   end
endmodule

// File: rtl/perceptron_trainer.sv
// Epoch/sample sequencer that trains a two-input perceptron with the classic
// perceptron rule, stopping on a zero-error epoch or the epoch limit.
module perceptron_trainer
   import perceptron_pkg::*;
#(
   parameter int MAX_EPOCHS   = DEF_MAX_EPOCHS,
   parameter int NEUR_LATENCY = DEF_NEUR_LATENCY
)(
   input  logic               clk,
   input  logic               rst_n,
   perceptron_trainer_if.slave bus
);
   state_t     state_q, state_d;
   logic [7:0] n_q, n_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] epochs_q, epochs_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] errors_last_q, errors_last_d;
   logic [7:0] lat_q, lat_d;
   logic       converged_q, converged_d;
   fp_t        x1_q, x1_d, x2_q, x2_d, result_q, result_d;
   logic       tgt_q, tgt_d;
   logic       rd, in_ld, w_ld, mispredict;

   assign mispredict = tgt_q != (result_q > fp_t'(0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         n_q           <= '0;
         addr_q        <= '0;
         epochs_q      <= '0;
         err_cnt_q     <= '0;
         errors_last_q <= '0;
         lat_q         <= '0;
         converged_q   <= 1'b0;
         x1_q          <= '0;
         x2_q          <= '0;
         tgt_q         <= 1'b0;
         result_q      <= '0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         addr_q        <= addr_d;
         epochs_q      <= epochs_d;
         err_cnt_q     <= err_cnt_d;
         errors_last_q <= errors_last_d;
         lat_q         <= lat_d;
         converged_q   <= converged_d;
         x1_q          <= x1_d;
         x2_q          <= x2_d;
         tgt_q         <= tgt_d;
         result_q      <= result_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      addr_d        = addr_q;
      epochs_d      = epochs_q;
      err_cnt_d     = err_cnt_q;
      errors_last_d = errors_last_q;
      lat_d         = lat_q;
      converged_d   = converged_q;
      x1_d          = x1_q;
      x2_d          = x2_q;
      tgt_d         = tgt_q;
      result_d      = result_q;
      rd            = 1'b0;
      in_ld         = 1'b0;
      w_ld          = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               epochs_d    = '0;
               converged_d = (bus.n_samples == 8'd0);
               if (bus.n_samples == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  n_d       = bus.n_samples;
                  err_cnt_d = '0;
                  addr_d    = '0;
                  state_d   = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            rd      = 1'b1;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            x1_d    = bus.sample_x1;
            x2_d    = bus.sample_x2;
            tgt_d   = bus.sample_target;
            in_ld   = 1'b1;
            lat_d   = '0;
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            if (lat_q == 8'(NEUR_LATENCY - 1)) begin
               result_d = bus.neur_result;
               state_d  = ST_UPDATE;
            end else begin
               lat_d = lat_q + 8'd1;
            end
         end
         ST_UPDATE: begin
            if (mispredict) begin
               w_ld = 1'b1;
               if (err_cnt_q != 8'hFF)
                  err_cnt_d = err_cnt_q + 8'd1;
            end
            if (addr_q == n_q - 8'd1) begin
               state_d = ST_EPOCH_END;
            end else begin
               addr_d  = addr_q + 8'd1;
               state_d = ST_FETCH;
            end
         end
         ST_EPOCH_END: begin
            epochs_d      = epochs_q + 8'd1;
            errors_last_d = err_cnt_q;
            if (err_cnt_q == 8'd0) begin
               converged_d = 1'b1;
               state_d     = ST_DONE;
            end else if (epochs_q + 8'd1 == 8'(MAX_EPOCHS)) begin
               converged_d = 1'b0;
               state_d     = ST_DONE;
            end else begin
               err_cnt_d = '0;
               addr_d    = '0;
               state_d   = ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides whatever the state wanted, including a pending weight write.
      if (bus.abort && state_q != ST_IDLE) begin
         state_d       = ST_IDLE;
         converged_d   = 1'b0;
         epochs_d      = epochs_q;
         errors_last_d = errors_last_q;
         rd            = 1'b0;
         in_ld         = 1'b0;
         w_ld          = 1'b0;
      end
   end

   perceptron_weight_update u_w1 (
      .w_i     (bus.neur_weight1),
      .x_i     (x1_q),
      .sub_i   (!tgt_q),
      .w_new_o (bus.neur_weight1_new)
   );

   perceptron_weight_update u_w2 (
      .w_i     (bus.neur_weight2),
      .x_i     (x2_q),
      .sub_i   (!tgt_q),
      .w_new_o (bus.neur_weight2_new)
   );

   assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bus.done           = (state_q == ST_DONE) && !bus.abort;
   assign bus.converged      = converged_q;
   assign bus.epochs         = epochs_q;
   assign bus.errors_last    = errors_last_q;
   assign bus.sample_addr    = addr_q;
   assign bus.sample_rd      = rd;
   assign bus.neur_IN1       = (state_q == ST_LOAD) ? bus.sample_x1 : x1_q;
   assign bus.neur_IN2       = (state_q == ST_LOAD) ? bus.sample_x2 : x2_q;
   assign bus.neur_IN_ld     = in_ld;
   assign bus.neur_weight_ld = w_ld;
endmodule
